// File: rtl/snake_round_ctrl.sv
// Round controller for the snake game: sequences IDLE/CLEAR/RUN/PAUSE/OVER,
// emits the game-step enable, filters direction keys and muxes the VGA stream.
module snake_round_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int RND_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key_n,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             game_done_i,
  output logic             game_rst_o,
  output logic             tick_o,
  output logic [1:0]       dir_o,
  output logic             fill_start_o,
  input  logic             fill_done_i,
  input  logic [X_W-1:0]   fill_x_i,
  input  logic [Y_W-1:0]   fill_y_i,
  input  logic [C_W-1:0]   fill_c_i,
  input  logic             fill_plot_i,
  input  logic [X_W-1:0]   game_x_i,
  input  logic [Y_W-1:0]   game_y_i,
  input  logic [C_W-1:0]   game_c_i,
  input  logic             game_plot_i,
  output logic [X_W-1:0]   vga_x_o,
  output logic [Y_W-1:0]   vga_y_o,
  output logic [C_W-1:0]   vga_c_o,
  output logic             vga_plot_o,
  output logic [2:0]       state_o,
  output logic [RND_W-1:0] rounds_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pend_dir;
  logic             pause_q;
  logic             pause_edge;
  logic             key_vld;
  logic [1:0]       key_dir;

  assign pause_edge = pause_i & ~pause_q;

  // Up beats left beats right beats down when several keys are held.
  always_comb begin
    key_vld = 1'b1;
    key_dir = 2'd0;
    if (!key_n[0])      key_dir = 2'd0;
    else if (!key_n[2]) key_dir = 2'd1;
    else if (!key_n[1]) key_dir = 2'd2;
    else if (!key_n[3]) key_dir = 2'd3;
    else                key_vld = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // End of round takes precedence over a simultaneous pause request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = CLEAR;
      CLEAR:   if (fill_done_i) state_d = RUN;
      RUN: begin
        if (game_done_i)     state_d = OVER;
        else if (pause_edge) state_d = PAUSE;
      end
      PAUSE:   if (pause_edge) state_d = RUN;
      OVER:    if (start_i) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_q      <= 1'b0;
      tick_o       <= 1'b0;
      dir_o        <= 2'd0;
      pend_dir     <= 2'd0;
      fill_start_o <= 1'b0;
      rounds_o     <= '0;
      cnt          <= '0;
    end else begin
      pause_q <= pause_i;
      tick_o  <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (start_i) begin
            dir_o        <= 2'd0;
            pend_dir     <= 2'd0;
            fill_start_o <= 1'b1;
          end
        end
        CLEAR: begin
          if (fill_done_i) begin
            fill_start_o <= 1'b0;
            cnt          <= '0;
          end
        end
        RUN: begin
          // A key naming the opposite of the current heading is dropped.
          if (key_vld && (key_dir != ~dir_o)) pend_dir <= key_dir;
          if (state_d == RUN) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == CNT_PRE) begin
              tick_o <= 1'b1;
              dir_o  <= pend_dir;
            end
          end
          if (game_done_i && (rounds_o != '1)) rounds_o <= rounds_o + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign game_rst_o = (state_q == IDLE) || (state_q == CLEAR);
  assign state_o    = state_q;

  always_comb begin
    vga_x_o    = '0;
    vga_y_o    = '0;
    vga_c_o    = '0;
    vga_plot_o = 1'b0;
    case (state_q)
      CLEAR: begin
        vga_x_o    = fill_x_i;
        vga_y_o    = fill_y_i;
        vga_c_o    = fill_c_i;
        vga_plot_o = fill_plot_i;
      end
      RUN, PAUSE: begin
        vga_x_o    = game_x_i;
        vga_y_o    = game_y_i;
        vga_c_o    = game_c_i;
        vga_plot_o = game_plot_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snake_round_ctrl.sv
// Directed bench for snake_round_ctrl with TICK_DIV=6 and a 2-bit round counter.
module tb_snake_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic       start_i, pause_i, game_done_i;
  logic       game_rst_o, tick_o, fill_start_o, fill_done_i;
  logic [1:0] dir_o;
  logic [7:0] fill_x_i, game_x_i, vga_x_o;
  logic [6:0] fill_y_i, game_y_i, vga_y_o;
  logic [2:0] fill_c_i, game_c_i, vga_c_o, state_o;
  logic       fill_plot_i, game_plot_i, vga_plot_o;
  logic [1:0] rounds_o;

  int vectors     = 0;
  int miscompares = 0;

  snake_round_ctrl #(
    .TICK_DIV(6), .X_W(8), .Y_W(7), .C_W(3), .RND_W(2)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .start_i(start_i), .pause_i(pause_i),
    .game_done_i(game_done_i), .game_rst_o(game_rst_o), .tick_o(tick_o),
    .dir_o(dir_o), .fill_start_o(fill_start_o), .fill_done_i(fill_done_i),
    .fill_x_i(fill_x_i), .fill_y_i(fill_y_i), .fill_c_i(fill_c_i),
    .fill_plot_i(fill_plot_i), .game_x_i(game_x_i), .game_y_i(game_y_i),
    .game_c_i(game_c_i), .game_plot_i(game_plot_i), .vga_x_o(vga_x_o),
    .vga_y_o(vga_y_o), .vga_c_o(vga_c_o), .vga_plot_o(vga_plot_o),
    .state_o(state_o), .rounds_o(rounds_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; key_n = 4'hF; start_i = 1'b0; pause_i = 1'b0;
    game_done_i = 1'b0; fill_done_i = 1'b0;
    fill_x_i = 8'h11; fill_y_i = 7'h22; fill_c_i = 3'h5; fill_plot_i = 1'b1;
    game_x_i = 8'hA0; game_y_i = 7'h3C; game_c_i = 3'h2; game_plot_i = 1'b1;

    // Reset state
    cycles(2);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_tick", 32'(tick_o), 32'd0);
    check("rst_dir", 32'(dir_o), 32'd0);
    check("rst_fill_start", 32'(fill_start_o), 32'd0);
    check("rst_rounds", 32'(rounds_o), 32'd0);
    check("rst_game_rst", 32'(game_rst_o), 32'd1);
    check("rst_vga_plot", 32'(vga_plot_o), 32'd0);
    check("rst_vga_x", 32'(vga_x_o), 32'd0);
    rst = 1'b0;
    step();
    check("idle_state", 32'(state_o), 32'd0);

    // Start -> CLEAR, fill engine held started until done
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("clear_state", 32'(state_o), 32'd1);
    check("clear_fill_start", 32'(fill_start_o), 32'd1);
    check("clear_game_rst", 32'(game_rst_o), 32'd1);
    check("clear_vga_x", 32'(vga_x_o), 32'h11);
    check("clear_vga_y", 32'(vga_y_o), 32'h22);
    check("clear_vga_c", 32'(vga_c_o), 32'h5);
    cycles(3);
    check("clear_hold_state", 32'(state_o), 32'd1);
    check("clear_hold_fill", 32'(fill_start_o), 32'd1);
    fill_done_i = 1'b1;
    step();
    fill_done_i = 1'b0;
    // RUN cycle 0, cnt=0
    check("run_state", 32'(state_o), 32'd2);
    check("run_fill_start", 32'(fill_start_o), 32'd0);
    check("run_game_rst", 32'(game_rst_o), 32'd0);
    check("run_vga_x", 32'(vga_x_o), 32'hA0);
    check("run_tick0", 32'(tick_o), 32'd0);
    for (int i = 1; i < 18; i++) begin
      step();
      check("tick_period", 32'(tick_o), 32'(i % 6 == 5));
    end
    check("run_dir0", 32'(dir_o), 32'd0);

    // Down against up is a reversal and never commits
    key_n = 4'b0111;
    for (int t = 0; t < 3; t++) begin
      cycles(6);
      check("down_tick", 32'(tick_o), 32'd1);
      check("down_rejected", 32'(dir_o), 32'd0);
    end
    // Left pressed only during a tick cycle commits at the following tick
    key_n = 4'b1011;
    step();
    key_n = 4'hF;
    check("left_not_yet", 32'(dir_o), 32'd0);
    cycles(4);
    check("left_pre_tick", 32'(dir_o), 32'd0);
    step();
    check("left_tick", 32'(tick_o), 32'd1);
    check("left_commit", 32'(dir_o), 32'd1);
    // Right against left is a reversal
    key_n = 4'b1101;
    cycles(6);
    check("right_rej_a", 32'(dir_o), 32'd1);
    cycles(6);
    check("right_rej_b", 32'(dir_o), 32'd1);
    // Up and left together: up has priority
    key_n = 4'b1010;
    cycles(5);
    check("upleft_pre", 32'(dir_o), 32'd1);
    step();
    check("upleft_tick", 32'(tick_o), 32'd1);
    check("upleft_commit", 32'(dir_o), 32'd0);
    key_n = 4'hF;

    // Pause at cnt=3
    cycles(4);
    check("prepause_tick", 32'(tick_o), 32'd0);
    pause_i = 1'b1;
    step();
    check("pause_state", 32'(state_o), 32'd3);
    check("pause_vga_x", 32'(vga_x_o), 32'hA0);
    key_n = 4'b1011;
    game_done_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      game_done_i = 1'b0;
      check("pause_hold_state", 32'(state_o), 32'd3);
      check("pause_no_tick", 32'(tick_o), 32'd0);
    end
    check("pause_rounds", 32'(rounds_o), 32'd0);
    key_n = 4'hF;
    pause_i = 1'b0;
    step();
    check("pause_fall_state", 32'(state_o), 32'd3);
    pause_i = 1'b1;
    step();
    check("resume_state", 32'(state_o), 32'd2);
    check("resume_tick_a", 32'(tick_o), 32'd0);
    step();
    check("resume_tick_b", 32'(tick_o), 32'd0);
    step();
    check("resume_tick_c", 32'(tick_o), 32'd1);
    check("pause_keys_ignored", 32'(dir_o), 32'd0);

    // Turn left, then done and pause edge together
    pause_i = 1'b0;
    key_n = 4'b1011;
    step();
    key_n = 4'hF;
    cycles(4);
    check("left2_pre", 32'(dir_o), 32'd0);
    step();
    check("left2_commit", 32'(dir_o), 32'd1);
    step();
    pause_i = 1'b1;
    game_done_i = 1'b1;
    step();
    pause_i = 1'b0;
    game_done_i = 1'b0;
    check("over_state", 32'(state_o), 32'd4);
    check("over_rounds", 32'(rounds_o), 32'd1);
    check("over_dir_held", 32'(dir_o), 32'd1);
    check("over_vga_plot", 32'(vga_plot_o), 32'd0);
    check("over_vga_x", 32'(vga_x_o), 32'd0);
    check("over_game_rst", 32'(game_rst_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("over_no_tick", 32'(tick_o), 32'd0);
    end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("restart_state", 32'(state_o), 32'd1);
    check("restart_dir", 32'(dir_o), 32'd0);
    check("restart_fill", 32'(fill_start_o), 32'd1);

    // Round counter saturates at 3
    for (int r = 2; r <= 4; r++) begin
      fill_done_i = 1'b1;
      step();
      fill_done_i = 1'b0;
      game_done_i = 1'b1;
      step();
      game_done_i = 1'b0;
      check("sat_state", 32'(state_o), 32'd4);
      check("sat_rounds", 32'(rounds_o), 32'((r > 3) ? 3 : r));
      start_i = 1'b1;
      step();
      start_i = 1'b0;
    end

    // Reset in the middle of CLEAR
    check("midclear_fill", 32'(fill_start_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_fill", 32'(fill_start_o), 32'd0);
    check("midrst_game_rst", 32'(game_rst_o), 32'd1);
    check("midrst_rounds", 32'(rounds_o), 32'd0);
    check("midrst_vga_plot", 32'(vga_plot_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snake_round_ctrl.md
Name: snake_round_ctrl

Overview:
- Parametrised round controller for the snake game. It sits between the board keys and the game engine, fill engine and VGA adapter.
- It sequences rounds: IDLE -> CLEAR -> RUN <-> PAUSE -> OVER.
- It emits a single-cycle game-step enable instead of a derived slow clock, so the whole design runs on one clock.
- It filters direction keys: reversal rejection and commit-on-tick. It muxes the fill or game pixel stream to the VGA adapter and counts finished rounds.

Parameters:
TICK_DIV, 500000, clk cycles per game step; must be >= 2 (bench uses 6).
X_W, 8, vga_x width.
Y_W, 7, vga_y width.
C_W, 3, colour width.
RND_W, 8, width of round counter.

Ports:
clk  in  1  system clock (CLOCK_50).
rst  in  1  synchronous, active-high reset.
key_n  in  4  active-low direction buttons: [0]=up, [2]=left, [1]=right, [3]=down.
start_i  in  1  level; begins a round from IDLE or OVER.
pause_i  in  1  level; each rising edge toggles RUN/PAUSE.
game_done_i  in  1  engine reports collision / end of round.
game_rst_o  out  1  hold game engine in reset (active-high).
tick_o  out  1  one-cycle game-step enable.
dir_o  out  2  committed direction: 0=up, 1=left, 2=right, 3=down.
fill_start_o  out  1  fill engine start.
fill_done_i  in  1  fill engine done.
fill_x_i / fill_y_i / fill_c_i / fill_plot_i  in  X_W/Y_W/C_W/1  fill pixel stream.
game_x_i / game_y_i / game_c_i / game_plot_i  in  X_W/Y_W/C_W/1  game pixel stream.
vga_x_o / vga_y_o / vga_c_o / vga_plot_o  out  X_W/Y_W/C_W/1  to VGA adapter.
state_o  out  3  IDLE=0, CLEAR=1, RUN=2, PAUSE=3, OVER=4.
rounds_o  out  RND_W  completed rounds.

Behaviour:
- All registers update on posedge clk.
- Reset values while rst=1 and on the cycle after:
  - state IDLE; tick_o=0; dir_o=0; pend_dir=0; fill_start_o=0; rounds_o=0.
  - game_rst_o=1; pause edge register=0.
  - VGA outputs 0.
- Reset mid-round: abandons everything immediately, with the same values as above.
- game_rst_o: combinational, =1 in IDLE and CLEAR; 0 otherwise.
- IDLE:
  - start_i=1 -> CLEAR.
  - dir_o and pend_dir are reloaded to 0 on this transition.
- CLEAR:
  - fill_start_o=1, held until fill_done_i is sampled high.
  - On that edge: fill_start_o<=0, state<=RUN, tick counter<=0.
- RUN:
  - Counter cnt counts 0..TICK_DIV-1 and wraps.
  - tick_o registered, =1 exactly on the cycle where cnt==TICK_DIV-1. One pulse every TICK_DIV cycles; first pulse TICK_DIV cycles after RUN entry.
- Key decode, every cycle in RUN only:
  - Priority key_n[0] > key_n[2] > key_n[1] > key_n[3]; no key -> pend_dir unchanged.
  - Candidate d is rejected if d is the reversal of dir_o (d == ~dir_o, i.e. up<->down, left<->right).
  - Otherwise pend_dir<=d.
- Commit: on the edge where cnt==TICK_DIV-2 (the edge raising tick_o), dir_o<=pend_dir. dir_o is therefore stable for the whole tick cycle. A key pressed during the tick cycle affects the next step only.
- Pause:
  - Rising edge of pause_i: (pause_i & ~pause_q) -> PAUSE.
  - In PAUSE: cnt frozen, tick_o=0, keys ignored, game_done_i ignored.
  - Next rising edge -> RUN, cnt resumes from its frozen value.
- game_done_i=1 in RUN -> OVER; rounds_o increments, saturating at all-ones. If game_done_i and a pause edge occur in the same cycle, done wins.
- OVER:
  - tick_o=0; dir_o held.
  - start_i=1 -> CLEAR (screen cleared before every round); dir_o and pend_dir are reloaded to 0 on this transition.
- VGA mux (combinational on state):
  - CLEAR: fill stream.
  - RUN and PAUSE: game stream.
  - IDLE and OVER: all zero, vga_plot_o=0.
- start_i is ignored in CLEAR, RUN and PAUSE.

Test Plan:
1. TICK_DIV=6; rst 2 cycles, start_i 1 cycle, fill_done_i 4 cycles later -> state 0->1->2, fill_start_o high until done sampled; first tick_o pulse exactly 6 cycles after RUN entry, then every 6 cycles; dir_o=0.
2. In RUN with dir_o=0 (up), hold key_n=4'b0111 (down) -> pend rejected, dir_o stays 0 across 3 ticks. Then key_n=4'b1011 (left) -> dir_o=1 from the next tick cycle. Then key_n=4'b1101 (right) -> rejected, dir_o stays 1.
3. key_n=4'b1010 (up+left together) while dir_o=1 -> up wins, dir_o=0 after the next tick. A key press landing exactly in a tick cycle -> committed one tick later.
4. Pause edge at cnt=3 -> state 3, no tick for 20 cycles, game_done_i pulse ignored, keys ignored. Second edge -> RUN, next tick exactly 3 cycles later.
5. game_done_i and pause rising edge in the same RUN cycle -> state 4, rounds_o 0->1. vga_plot_o=0 despite game_plot_i=1. start_i -> CLEAR with dir_o=0.
6. RND_W=2: 4 rounds -> rounds_o saturates at 3. Assert rst mid-CLEAR -> fill_start_o=0, state 0, game_rst_o=1 the next cycle.
